// File: rtl/avalon_pwm_pio_pkg.sv
// Shared register map and CTRL bit positions for the Avalon-MM PWM/PIO block.
package avalon_pwm_pio_pkg;

  localparam logic [5:0] ADDR_DATA      = 6'h00;
  localparam logic [5:0] ADDR_MODE      = 6'h01;
  localparam logic [5:0] ADDR_PERIOD    = 6'h02;
  localparam logic [5:0] ADDR_CTRL      = 6'h03;
  localparam logic [5:0] ADDR_OUTSET    = 6'h04;
  localparam logic [5:0] ADDR_OUTCLEAR  = 6'h05;
  localparam logic [5:0] ADDR_DUTY_BASE = 6'h20;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_INVERT = 1;

endpackage

// File: rtl/avalon_pwm_pio_pwm_timebase.sv
// Prescaler plus free-running PWM counter; wrap marks the last tick of a frame.
module pwm_timebase #(
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [PRESCALE_BITS-1:0] period,
  input  logic                     period_wr,
  output logic [PWM_BITS-1:0]      pwm_cnt,
  output logic                     wrap
);

  logic [PRESCALE_BITS-1:0] presc_r;
  logic                     tick_s;

  assign tick_s = enable && (presc_r == period);
  assign wrap   = tick_s && (pwm_cnt == {PWM_BITS{1'b1}});

  // Prescaler and PWM counter; both parked at zero while disabled.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      presc_r <= '0;
      pwm_cnt <= '0;
    end else begin
      if (period_wr || tick_s) begin
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + PRESCALE_BITS'(1);
      end
      if (tick_s) begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end else begin
        pwm_cnt <= pwm_cnt;
      end
    end
  end

endmodule

// File: rtl/avalon_pwm_pio.sv
// Avalon-MM slave driving WIDTH outputs, each either static (DATA) or PWM-gated.
module avalon_pwm_pio
  import avalon_pwm_pio_pkg::*;
#(
  parameter int WIDTH         = 14,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic                     wr_s;
  logic                     rd_s;
  logic                     period_wr_s;
  logic                     enable_s;
  logic                     wrap_s;
  logic [PWM_BITS-1:0]      pwm_cnt_s;
  logic [WIDTH-1:0]         data_r;
  logic [WIDTH-1:0]         mode_r;
  logic [PRESCALE_BITS-1:0] period_r;
  logic [1:0]               ctrl_r;
  logic [WIDTH-1:0]         level_s;
  logic [PWM_BITS:0]        shadow_s [WIDTH];
  logic [31:0]              rd_data_s;
  logic                     unused_wdata_s;

  assign wr_s           = chipselect && !write_n;
  assign rd_s           = chipselect && !read_n;
  assign period_wr_s    = wr_s && (address == ADDR_PERIOD);
  assign enable_s       = ctrl_r[CTRL_ENABLE];
  assign unused_wdata_s = ^writedata;

  pwm_timebase #(
    .PWM_BITS      (PWM_BITS),
    .PRESCALE_BITS (PRESCALE_BITS)
  ) u_timebase (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable_s),
    .period    (period_r),
    .period_wr (period_wr_s),
    .pwm_cnt   (pwm_cnt_s),
    .wrap      (wrap_s)
  );

  // Control/data register writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r   <= '0;
      mode_r   <= '0;
      period_r <= '0;
      ctrl_r   <= 2'b00;
    end else if (wr_s) begin
      case (address)
        ADDR_DATA:     data_r   <= writedata[WIDTH-1:0];
        ADDR_MODE:     mode_r   <= writedata[WIDTH-1:0];
        ADDR_PERIOD:   period_r <= writedata[PRESCALE_BITS-1:0];
        ADDR_CTRL:     ctrl_r   <= writedata[1:0];
        ADDR_OUTSET:   data_r   <= data_r | writedata[WIDTH-1:0];
        ADDR_OUTCLEAR: data_r   <= data_r & ~writedata[WIDTH-1:0];
        default:       data_r   <= data_r;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [PWM_BITS:0] shadow_r;
    logic [PWM_BITS:0] active_r;
    logic              duty_wr_s;

    assign duty_wr_s   = wr_s && (address == ADDR_DUTY_BASE + 6'(i));
    assign shadow_s[i] = shadow_r;
    assign level_s[i]  = enable_s && data_r[i] &&
                         (!mode_r[i] || ({1'b0, pwm_cnt_s} < active_r));

    // Shadow duty, host-visible.
    always_ff @(posedge clk) begin
      if (reset) begin
        shadow_r <= '0;
      end else if (duty_wr_s) begin
        shadow_r <= writedata[PWM_BITS:0];
      end
    end

    // Active duty tracks the shadow while idle so enabling picks it up at once.
    always_ff @(posedge clk) begin
      if (reset) begin
        active_r <= '0;
      end else if (!enable_s || wrap_s) begin
        active_r <= shadow_r;
      end
    end
  end

  // Read mux; anything unmapped or out of range reads zero.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (address)
      ADDR_DATA:   rd_data_s = 32'(data_r);
      ADDR_MODE:   rd_data_s = 32'(mode_r);
      ADDR_PERIOD: rd_data_s = 32'(period_r);
      ADDR_CTRL:   rd_data_s = {30'h0, ctrl_r};
      default: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (address == ADDR_DUTY_BASE + 6'(i)) begin
            rd_data_s = 32'(shadow_s[i]);
          end else begin
            rd_data_s = rd_data_s;
          end
        end
      end
    endcase
  end

  // Read data register, holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 32'h0000_0000;
    end else if (rd_s) begin
      readdata <= rd_data_s;
    end
  end

  // Output register with optional polarity inversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_port <= '0;
    end else begin
      out_port <= level_s ^ {WIDTH{ctrl_r[CTRL_INVERT]}};
    end
  end

endmodule

// File: tb/tb_avalon_pwm_pio.sv
// Randomised and directed bench for avalon_pwm_pio against a cycle-level behavioural model.
module tb_avalon_pwm_pio;

  localparam int WIDTH = 14;
  localparam int PB    = 8;
  localparam int PSB   = 16;
  localparam int NCNT  = 1 << PB;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [5:0]       address = 6'h00;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic             read_n = 1'b1;
  logic [31:0]      writedata = 32'h0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  avalon_pwm_pio #(.WIDTH(WIDTH), .PWM_BITS(PB), .PRESCALE_BITS(PSB)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata),
    .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit check_en = 1'b0;
  bit counting = 1'b0;
  int hi = 0;

  // behavioural model state
  logic [WIDTH-1:0] m_data, m_mode, m_out;
  logic [PSB-1:0]   m_period;
  logic [1:0]       m_ctrl;
  logic [31:0]      m_rd;
  int m_shadow [WIDTH];
  int m_active [WIDTH];
  int m_presc, m_cnt;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] read_val(int a);
    if (a == 0) return 32'(m_data);
    if (a == 1) return 32'(m_mode);
    if (a == 2) return 32'(m_period);
    if (a == 3) return 32'(m_ctrl);
    if (a >= 32 && a < 32 + WIDTH) return 32'(m_shadow[a-32]);
    return 32'h0;
  endfunction

  task automatic model_step();
    bit wr, rd, en, tick, wrap;
    int a;
    logic [31:0] d;
    logic [WIDTH-1:0] lvl;
    wr = chipselect && !write_n;
    rd = chipselect && !read_n;
    a  = int'(address);
    d  = writedata;
    if (reset) begin
      m_data = '0; m_mode = '0; m_period = '0; m_ctrl = 2'b00;
      m_out = '0; m_rd = 32'h0; m_presc = 0; m_cnt = 0;
      for (int i = 0; i < WIDTH; i++) begin
        m_shadow[i] = 0;
        m_active[i] = 0;
      end
      return;
    end
    en = m_ctrl[0];
    for (int i = 0; i < WIDTH; i++)
      lvl[i] = en && m_data[i] && (!m_mode[i] || (m_cnt < m_active[i]));
    m_out = m_ctrl[1] ? ~lvl : lvl;
    if (rd) m_rd = read_val(a);
    tick = en && (m_presc == int'(m_period));
    wrap = tick && (m_cnt == NCNT - 1);
    if (!en) begin
      m_presc = 0;
      m_cnt = 0;
    end else begin
      m_presc = (tick || (wr && a == 2)) ? 0 : m_presc + 1;
      if (tick) m_cnt = (m_cnt + 1) % NCNT;
    end
    for (int i = 0; i < WIDTH; i++)
      if (!en || wrap) m_active[i] = m_shadow[i];
    if (wr) begin
      if (a == 0) m_data = d[WIDTH-1:0];
      else if (a == 1) m_mode = d[WIDTH-1:0];
      else if (a == 2) m_period = d[PSB-1:0];
      else if (a == 3) m_ctrl = d[1:0];
      else if (a == 4) m_data = m_data | d[WIDTH-1:0];
      else if (a == 5) m_data = m_data & ~d[WIDTH-1:0];
      else if (a >= 32 && a < 32 + WIDTH) m_shadow[a-32] = int'(d[PB:0]);
    end
  endtask

  // every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (check_en) begin
      check("out_port_model", 32'(out_port), 32'(m_out));
      check("readdata_model", readdata, m_rd);
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (counting && out_port[0]) hi++;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [5:0] a);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    cyc();
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic wait_frame();
    int b = 0;
    while (!(m_ctrl[0] && m_cnt == 0 && m_presc == 0) && b < 5000) begin
      cyc();
      b++;
    end
    if (b >= 5000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL frame_wait: no frame start within %0d cycles", b);
    end
  endtask

  task automatic measure(input int n, output int highs);
    hi = 0;
    counting = 1'b1;
    repeat (n) cyc();
    counting = 1'b0;
    highs = hi;
  endtask

  task automatic set_pwm(input int duty, input int period);
    bus_write(6'h03, 32'h0);
    bus_write(6'h02, 32'(period));
    bus_write(6'h20, 32'(duty));
    bus_write(6'h00, 32'h1);
    bus_write(6'h01, 32'h1);
    bus_write(6'h03, 32'h1);
    wait_frame();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    int pick;
    logic [5:0] addrs [$];

    // reset state
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    check_en = 1'b1;
    check("reset_out", 32'(out_port), 32'h0);
    check("reset_readdata", readdata, 32'h0);

    // static mode
    bus_write(6'h00, 32'h0000_2A5A);
    bus_write(6'h03, 32'h1);
    cyc();
    check("static_data", 32'(out_port), 32'h2A5A);
    bus_write(6'h04, 32'h0000_0001);
    cyc();
    check("static_outset", 32'(out_port), 32'h2A5B);
    bus_write(6'h05, 32'h0000_2000);
    cyc();
    check("static_outclear", 32'(out_port), 32'h0A5B);

    // PWM duty 64, two frames
    set_pwm(64, 0);
    measure(NCNT, h);
    check("pwm64_frame_a", 32'(h), 32'd64);
    measure(NCNT, h);
    check("pwm64_frame_b", 32'(h), 32'd64);

    // duty boundaries
    set_pwm(0, 0);
    measure(NCNT, h);
    check("duty0_highs", 32'(h), 32'd0);
    set_pwm(256, 0);
    measure(NCNT, h);
    check("duty256_highs", 32'(h), 32'd256);
    set_pwm(255, 0);
    measure(NCNT, h);
    check("duty255_highs", 32'(h), 32'd255);

    // shadowing: change 64 -> 192 mid-frame
    set_pwm(64, 0);
    hi = 0;
    counting = 1'b1;
    repeat (100) cyc();
    bus_write(6'h20, 32'd192);
    bus_read(6'h20);
    check("shadow_readback", readdata, 32'd192);
    repeat (NCNT - 102) cyc();
    counting = 1'b0;
    check("shadow_old_frame", 32'(hi), 32'd64);
    wait_frame();
    measure(NCNT, h);
    check("shadow_new_frame", 32'(h), 32'd192);

    // prescale: PERIOD=3 gives a 1024-clock frame
    set_pwm(64, 3);
    measure(4 * NCNT, h);
    check("prescale_highs", 32'(h), 32'd256);

    // invert while disabled
    bus_write(6'h03, 32'h2);
    cyc();
    check("invert_disabled", 32'(out_port), 32'h3FFF);

    // reset mid-frame with a pending shadow duty
    set_pwm(128, 0);
    repeat (50) cyc();
    bus_write(6'h20, 32'd200);
    reset = 1'b1;
    cyc();
    check("midframe_reset_out", 32'(out_port), 32'h0);
    reset = 1'b0;
    addrs = {6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h20, 6'h21,
             6'h2D, 6'(32 + WIDTH), 6'h3F};
    foreach (addrs[k]) begin
      bus_read(addrs[k]);
      check($sformatf("read0_addr_%0h", addrs[k]), readdata, 32'h0);
    end

    // randomised traffic
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 199) == 0);
      chipselect = ($urandom_range(0, 3) != 0);
      write_n = 1'($urandom_range(0, 1));
      read_n = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 9);
      if (pick < 4) address = 6'($urandom_range(0, 5));
      else if (pick < 8) address = 6'(32 + $urandom_range(0, 15));
      else address = 6'($urandom_range(0, 63));
      writedata = $urandom();
      if (address == 6'h02) writedata[15:0] = 16'($urandom_range(0, 3));
      if (address == 6'h03) writedata[0] = ($urandom_range(0, 3) != 0);
      cyc();
    end
    reset = 1'b0;
    chipselect = 1'b0;
    write_n = 1'b1;
    read_n = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
